fft_sdf_stage16: RTL and testbench

Radix-2 single-path delay-feedback (SDF) butterfly stage for one 16-point decimation-in-frequency pass of the streaming FFT pipeline. The block consumes the twiddle/phase stream produced by the stage's twiddle ROM (`state`, `w_r`, `w_i`) together with the complex sample stream. It emits one complex result per accepted sample, after a pipeline fill of 8 samples. Results feed the next pipeline stage.

---
 rtl/fft_sdf_stage16_if.sv | 31 +++
 rtl/fft_sdf_stage16.sv | 108 ++++++++++
 tb/tb_fft_sdf_stage16.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fft_sdf_stage16_if.sv
// Sample/twiddle stream bundle for the 16-point SDF butterfly stage.
//   in_valid          : din_*, state and w_* are valid this cycle
//   state[1:0]        : 0 fill, 1 butterfly, 2 twiddle, 3 reserved (acts as fill)
//   w_r / w_i         : twiddle W16^k, signed Q(FRAC)
//   din_r / din_i     : input sample, signed
//   out_valid         : dout_* valid this cycle
//   dout_r / dout_i   : output sample, signed
// master drives the input side and observes results; slave is the stage.
interface fft_sdf_stage16_if #(
  parameter int DW = 24
);
  logic                 in_valid;
  logic [1:0]           state;
  logic signed [DW-1:0] w_r;
  logic signed [DW-1:0] w_i;
  logic signed [DW-1:0] din_r;
  logic signed [DW-1:0] din_i;
  logic                 out_valid;
  logic signed [DW-1:0] dout_r;
  logic signed [DW-1:0] dout_i;

  modport master (
    output in_valid, state, w_r, w_i, din_r, din_i,
    input  out_valid, dout_r, dout_i
  );

  modport slave (
    input  in_valid, state, w_r, w_i, din_r, din_i,
    output out_valid, dout_r, dout_i
  );
endinterface

// File: rtl/fft_sdf_stage16.sv
// Radix-2 single-path delay-feedback butterfly stage, one 16-point DIF pass.
// Each accepted sample is handled according to its phase:
//   fill     : push din, no output
//   butterfly: output head + din, push head - din
//   twiddle  : output head * w (floored, wrapped), push din
// head is the delay-line entry written DEPTH accepted samples earlier.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears delay line and outputs)
//   bus   : fft_sdf_stage16_if slave (input stream in, result stream out)
// Latency is one cycle; dout_* holds between producing cycles.
module fft_sdf_stage16 #(
  parameter int DW    = 24,
  parameter int FRAC  = 8,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_sdf_stage16_if.slave   bus
);

  localparam logic [1:0] ST_BFLY = 2'd1;
  localparam logic [1:0] ST_TWID = 2'd2;

  // Sign-extend a DW-bit operand to full product width.
  function automatic logic signed [2*DW-1:0] sext(input logic signed [DW-1:0] x);
    return {{DW{x[DW-1]}}, x};
  endfunction

  // Drop FRAC fraction bits with floor (arithmetic shift), then wrap to DW.
  function automatic logic signed [DW-1:0] floor_wrap(input logic signed [2*DW-1:0] p);
    return DW'(p >>> FRAC);
  endfunction

  logic signed [DW-1:0] dl_r [DEPTH];
  logic signed [DW-1:0] dl_i [DEPTH];

  logic signed [DW-1:0] head_r, head_i;
  assign head_r = dl_r[DEPTH-1];
  assign head_i = dl_i[DEPTH-1];

  // ---- stage p0: combinational butterfly / twiddle datapath ----
  logic signed [2*DW-1:0] pr_full_p0, pi_full_p0;
  logic signed [DW-1:0]   push_r_p0, push_i_p0;
  logic signed [DW-1:0]   res_r_p0, res_i_p0;
  logic                   vld_p0;

  always_comb begin
    pr_full_p0 = sext(head_r) * sext(bus.w_r) - sext(head_i) * sext(bus.w_i);
    pi_full_p0 = sext(head_r) * sext(bus.w_i) + sext(head_i) * sext(bus.w_r);
  end

  always_comb begin
    push_r_p0 = bus.din_r;
    push_i_p0 = bus.din_i;
    res_r_p0  = head_r + bus.din_r;
    res_i_p0  = head_i + bus.din_i;
    vld_p0    = 1'b0;
    case (bus.state)
      ST_BFLY: begin
        push_r_p0 = head_r - bus.din_r;
        push_i_p0 = head_i - bus.din_i;
        vld_p0    = bus.in_valid;
      end
      ST_TWID: begin
        res_r_p0 = floor_wrap(pr_full_p0);
        res_i_p0 = floor_wrap(pi_full_p0);
        vld_p0   = bus.in_valid;
      end
      default: ;
    endcase
  end

  // ---- stage p1: delay line advance and registered outputs ----
  logic                 vld_p1;
  logic signed [DW-1:0] dout_r_p1, dout_i_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      dout_r_p1 <= '0;
      dout_i_p1 <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dl_r[k] <= '0;
        dl_i[k] <= '0;
      end
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        dout_r_p1 <= res_r_p0;
        dout_i_p1 <= res_i_p0;
      end
      if (bus.in_valid) begin
        dl_r[0] <= push_r_p0;
        dl_i[0] <= push_i_p0;
        for (int k = 1; k < DEPTH; k++) begin
          dl_r[k] <= dl_r[k-1];
          dl_i[k] <= dl_i[k-1];
        end
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.dout_r    = dout_r_p1;
  assign bus.dout_i    = dout_i_p1;

endmodule

// File: tb/tb_fft_sdf_stage16.sv
module tb_fft_sdf_stage16;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_sdf_stage16_if #(.DW(DW)) bus ();

  fft_sdf_stage16 #(.DW(DW), .FRAC(8), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a FIFO of accepted pushes; head is the oldest entry.
  longint q_r[$];
  longint q_i[$];
  longint m_dr, m_di;
  bit     m_vld;

  longint tw_r[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  longint tw_i[8] = '{0, -98, -181, -237, -256, -237, -181, -98};

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint x);
    longint t;
    t = x & ((64'sd1 <<< DW) - 1);
    if (t >= (64'sd1 <<< (DW - 1))) t = t - (64'sd1 <<< DW);
    return t;
  endfunction

  function automatic longint floor_div256(input longint x);
    longint q;
    q = x / 256;
    if ((x % 256) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    q_r.delete();
    q_i.delete();
    for (int k = 0; k < 8; k++) begin
      q_r.push_back(0);
      q_i.push_back(0);
    end
    m_dr  = 0;
    m_di  = 0;
    m_vld = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_vld"}, longint'(bus.out_valid), longint'(m_vld));
    check({tag, "_dr"}, longint'(bus.dout_r), m_dr);
    check({tag, "_di"}, longint'(bus.dout_i), m_di);
  endtask

  // One clock: drive, advance the model, check registered outputs at edge+1.
  task automatic step(input bit v, input logic [1:0] st, input longint dr, input longint di,
                      input longint wr, input longint wi, input string tag);
    longint hr, hi;
    logic [DW-1:0] tmp;
    bus.in_valid = v;
    bus.state    = st;
    tmp = DW'(dr); bus.din_r = tmp;
    tmp = DW'(di); bus.din_i = tmp;
    tmp = DW'(wr); bus.w_r   = tmp;
    tmp = DW'(wi); bus.w_i   = tmp;
    @(posedge clk);
    #1;
    m_vld = 0;
    if (v) begin
      hr = q_r.pop_front();
      hi = q_i.pop_front();
      if (st == 2'd1) begin
        m_vld = 1;
        m_dr = wrap(hr + dr);
        m_di = wrap(hi + di);
        q_r.push_back(wrap(hr - dr));
        q_i.push_back(wrap(hi - di));
      end else if (st == 2'd2) begin
        m_vld = 1;
        m_dr = wrap(floor_div256(hr * wr - hi * wi));
        m_di = wrap(floor_div256(hr * wi + hi * wr));
        q_r.push_back(dr);
        q_i.push_back(di);
      end else begin
        q_r.push_back(dr);
        q_i.push_back(di);
      end
    end
    check_outputs(tag);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 2'd0, 0, 0, 0, 0, "gap");
  endtask

  task automatic scen_dc();
    for (int k = 0; k < 8; k++) step(1, 2'd0, 256, 0, 0, 0, "dc_fill");
    for (int k = 0; k < 8; k++) begin
      step(1, 2'd1, 256, 0, 0, 0, "dc_bf");
      check("dc_bf_lit_r", longint'(bus.dout_r), 512);
      check("dc_bf_lit_i", longint'(bus.dout_i), 0);
    end
    for (int k = 0; k < 8; k++) begin
      step(1, 2'd2, 0, 0, tw_r[k], tw_i[k], "dc_tw");
      check("dc_tw_lit_r", longint'(bus.dout_r), 0);
      check("dc_tw_lit_i", longint'(bus.dout_i), 0);
    end
  endtask

  task automatic scen_twiddle(input int gap);
    for (int k = 0; k < 8; k++) begin
      step(1, 2'd0, 256, 0, 0, 0, "tw_fill");
      idle(gap);
    end
    for (int k = 0; k < 8; k++) begin
      step(1, 2'd1, 0, 0, 0, 0, "tw_bf");
      check("tw_bf_lit_r", longint'(bus.dout_r), 256);
      check("tw_bf_lit_i", longint'(bus.dout_i), 0);
      idle(gap);
    end
    for (int k = 0; k < 8; k++) begin
      step(1, 2'd2, 0, 0, tw_r[k], tw_i[k], "tw_tw");
      check("tw_tw_lit_r", longint'(bus.dout_r), tw_r[k]);
      check("tw_tw_lit_i", longint'(bus.dout_i), tw_i[k]);
      idle(gap);
    end
  endtask

  initial begin
    logic [DW-1:0] r1, r2, r3, r4;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.state = 0;
    bus.din_r = 0; bus.din_i = 0; bus.w_r = 0; bus.w_i = 0;
    model_reset();
    #12;
    check_outputs("reset");
    rst_n = 1'b1;

    scen_dc();
    scen_twiddle(0);
    scen_twiddle(3);

    // floor rounding: head = (-1,0) times (181,-181)
    for (int k = 0; k < 8; k++) step(1, 2'd0, -1, 0, 0, 0, "fl_fill");
    step(1, 2'd2, 0, 0, 181, -181, "fl_tw");
    check("floor_lit_r", longint'(bus.dout_r), -1);
    check("floor_lit_i", longint'(bus.dout_i), 0);

    // wrap: 0x7FFFFF + 1, then pushed 0x7FFFFE returns as head
    for (int k = 0; k < 7; k++) step(1, 2'd0, 0, 0, 0, 0, "wr_pad");
    for (int k = 0; k < 8; k++) step(1, 2'd0, 64'h7FFFFF, 0, 0, 0, "wr_fill");
    step(1, 2'd1, 1, 0, 0, 0, "wr_bf");
    check("wrap_lit_r", longint'(bus.dout_r), -64'sd8388608);
    for (int k = 0; k < 7; k++) step(1, 2'd1, 0, 0, 0, 0, "wr_bf2");
    step(1, 2'd2, 0, 0, 256, 0, "wr_tw");
    check("wrap_head_lit_r", longint'(bus.dout_r), 64'h7FFFFE);

    // reset in the middle of a butterfly phase
    for (int k = 0; k < 8; k++) step(1, 2'd0, 300 + k, -k, 0, 0, "rs_fill");
    for (int k = 0; k < 3; k++) step(1, 2'd1, 7, 9, 0, 0, "rs_bf");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    check_outputs("rst_hold");
    scen_dc();

    // randomized phases, data, twiddles and stalls
    for (int n = 0; n < 400; n++) begin
      r1 = DW'($urandom); r2 = DW'($urandom); r3 = DW'($urandom); r4 = DW'($urandom);
      step(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
           longint'($signed(r1)), longint'($signed(r2)),
           longint'($signed(r3)), longint'($signed(r4)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
